// File: rtl/instr_decode_stage_pkg.sv
// Shared constants and bundle types for the instruction decode stage.
// Immediate-select encodings match the immediate generator's select input.
package instr_decode_stage_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 8;

    localparam logic [2:0] IMM_U     = 3'd0;
    localparam logic [2:0] IMM_J     = 3'd1;
    localparam logic [2:0] IMM_I     = 3'd2;
    localparam logic [2:0] IMM_SHAMT = 3'd3;
    localparam logic [2:0] IMM_LD    = 3'd4;
    localparam logic [2:0] IMM_S     = 3'd5;
    localparam logic [2:0] IMM_B     = 3'd6;
    localparam logic [2:0] IMM_NONE  = 3'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [2:0]  immsrc;
        logic [11:0] inx12;
        logic        illegal;
    } pack_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational opcode classifier: picks the immediate select and packs
// the 12-bit immediate field in the order the immediate generator expects.
module instr_field_pack
    import instr_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output pack_t       pack
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        pack.immsrc  = IMM_NONE;
        pack.inx12   = 12'h000;
        pack.illegal = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC: begin
                pack.immsrc = IMM_U;
            end
            OP_JAL: begin
                pack.immsrc = IMM_J;
            end
            OP_OPIMM: begin
                pack.immsrc = (funct3 == 3'b001 || funct3 == 3'b101)
                            ? IMM_SHAMT : IMM_I;
                pack.inx12  = instr[31:20];
            end
            OP_LOAD, OP_JALR: begin
                pack.immsrc = IMM_LD;
                pack.inx12  = instr[31:20];
            end
            OP_STORE: begin
                pack.immsrc = IMM_S;
                pack.inx12  = {instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                // bit0 carries imm[11] so the generator can splice it directly
                pack.immsrc = IMM_B;
                pack.inx12  = {instr[31], instr[30:25], instr[11:8], instr[7]};
            end
            OP_OP: begin
                pack.immsrc = IMM_NONE;
            end
            default: begin
                pack.immsrc  = IMM_NONE;
                pack.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: valid/ready pipe register holding decoded
// fields, immediate select and a saturating illegal-instruction counter.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       immsrc,
    output logic [19:0]      inx20,
    output logic [11:0]      inx12,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    pack_t pack;
    logic  accept;

    instr_field_pack u_pack (
        .instr (in_instr[31:0]),
        .pack  (pack)
    );

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            immsrc    <= IMM_NONE;
            inx20     <= '0;
            inx12     <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct3    <= '0;
            funct7    <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            immsrc    <= pack.immsrc;
            inx20     <= in_instr[31:12];
            inx12     <= pack.inx12;
            rd        <= in_instr[11:7];
            rs1       <= in_instr[19:15];
            rs2       <= in_instr[24:20];
            funct3    <= in_instr[14:12];
            funct7    <= in_instr[31:25];
            illegal   <= pack.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && pack.illegal && !(&illegal_cnt)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
